// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM update scheduler slice.
package pwm_pkg;

    localparam int PHASE_W = 8;
    localparam logic [PHASE_W-1:0] DUTY_FULL = 8'hFF;
    localparam int N_OUT_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shared PWM comparator: full-scale duty is a steady high, zero is a steady low.
    function automatic logic pwm_level(input logic [PHASE_W-1:0] phase,
                                       input logic [PHASE_W-1:0] duty);
        return (duty == DUTY_FULL) ? 1'b1 : (phase < duty);
    endfunction

endpackage

// File: rtl/pwm_update_sched_if.sv
// Configuration bus from the SPI register block into the PWM scheduler.
// The master side presents register values plus a one-cycle commit strobe.
interface pwm_update_sched_if #(
    parameter int N_OUT = pwm_pkg::N_OUT_DEFAULT
);

    logic [N_OUT-1:0]            cfg_en_out;
    logic [N_OUT-1:0]            cfg_en_pwm;
    logic [pwm_pkg::PHASE_W-1:0] cfg_duty;
    logic                        cfg_update;

    modport master (
        output cfg_en_out,
        output cfg_en_pwm,
        output cfg_duty,
        output cfg_update
    );

    modport slave (
        input cfg_en_out,
        input cfg_en_pwm,
        input cfg_duty,
        input cfg_update
    );

endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler plus 8-bit phase counter.
// Counters are held at zero whenever the scheduler is not running.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESC_MAX = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_run,
    input  logic               i_clear,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_tick,
    output logic               o_boundary
);

    localparam int PRESC_W = (PRESC_MAX < 1) ? 1 : $clog2(PRESC_MAX + 1);

    logic [PRESC_W-1:0] r_presc;
    logic [PHASE_W-1:0] r_phase;
    logic               w_tick;

    assign w_tick     = i_run && (r_presc == PRESC_W'(PRESC_MAX));
    assign o_tick     = w_tick;
    assign o_boundary = w_tick && (r_phase == {PHASE_W{1'b1}});
    assign o_phase    = r_phase;

    // Prescaler wraps at its terminal count; phase advances once per wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_phase <= '0;
        end else if (i_clear || !i_run) begin
            r_presc <= '0;
            r_phase <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_phase <= r_phase + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_update_sched.sv
// PWM update scheduler: shadows SPI configuration and applies it to the
// 16-channel PWM output stage.
// PWM_SYNC_UPDATE_EN defined: commits are deferred to the next period
// boundary (sampling cfg_* on that cycle), so a period is never cut short.
// PWM_SYNC_UPDATE_EN undefined: commits load on the next edge in any state
// and pending is always 0.
module pwm_update_sched
    import pwm_pkg::*;
#(
    parameter int N_OUT     = N_OUT_DEFAULT,
    parameter int PRESC_MAX = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_update_sched_if.slave cfg_if,
    output logic [N_OUT-1:0]  o_out,
    output logic              o_period_start,
    output logic              o_pending,
    output logic              o_active
);

    state_t             r_state;
    state_t             w_state_next;

    logic [N_OUT-1:0]   r_en_out;
    logic [N_OUT-1:0]   r_en_pwm;
    logic [PHASE_W-1:0] r_duty;
    logic               r_pending;
    logic               r_period_start;
    logic [N_OUT-1:0]   r_out;

    logic [PHASE_W-1:0] w_phase;
    logic               w_tick;
    logic               w_boundary;
    logic               w_boundary_evt;
    logic               w_run;
    logic               w_tb_clear;
    logic               w_load;
    logic               w_pending_next;
    logic               w_period_start_next;
    logic               w_pwm_raw;
    logic [N_OUT-1:0]   w_chan;

    pwm_timebase #(
        .PRESC_MAX (PRESC_MAX)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (w_run),
        .i_clear    (w_tb_clear),
        .o_phase    (w_phase),
        .o_tick     (w_tick),
        .o_boundary (w_boundary)
    );

    // The last phase-255 tick of a running period.
    assign w_boundary_evt = w_tick & w_boundary;
    assign w_run          = (r_state == RUN);

`ifdef PWM_SYNC_UPDATE_EN
    // IDLE commits load at once; RUN commits wait for the boundary and take
    // whatever cfg_* holds on that cycle (last write wins).
    assign w_load = (r_state == IDLE) ? cfg_if.cfg_update
                                      : (w_boundary_evt && (r_pending || cfg_if.cfg_update));
`else
    assign w_load = cfg_if.cfg_update;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, timebase control, period_start and pending updates.
    always_comb begin
        w_state_next        = r_state;
        w_pending_next      = 1'b0;
        case (r_state)
            IDLE: begin
                // Start once a non-zero enable set sits in the shadow, unless
                // it is being overwritten with all-off on this very cycle.
                if ((r_en_out != '0) && !(w_load && (cfg_if.cfg_en_out == '0))) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_load && (cfg_if.cfg_en_out == '0)) begin
                    w_state_next = IDLE;
                end
`ifdef PWM_SYNC_UPDATE_EN
                if (w_boundary_evt) begin
                    w_pending_next = 1'b0;
                end else begin
                    w_pending_next = r_pending | cfg_if.cfg_update;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        w_tb_clear          = (w_state_next != r_state);
        w_period_start_next = ((r_state == IDLE) && (w_state_next == RUN)) || w_boundary_evt;
    end

    // Shadow configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= '0;
            r_en_pwm <= '0;
            r_duty   <= '0;
        end else if (w_load) begin
            r_en_out <= cfg_if.cfg_en_out;
            r_en_pwm <= cfg_if.cfg_en_pwm;
            r_duty   <= cfg_if.cfg_duty;
        end
    end

    assign w_pwm_raw = pwm_level(w_phase, r_duty);

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
            assign w_chan[gi] = r_en_out[gi] & (r_en_pwm[gi] ? w_pwm_raw : 1'b1);
        end
    endgenerate

    // Registered output stage and status flags; outputs are forced low in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
            r_pending      <= 1'b0;
        end else begin
            r_out          <= w_run ? w_chan : '0;
            r_period_start <= w_period_start_next;
            r_pending      <= w_pending_next;
        end
    end

    assign o_out          = r_out;
    assign o_period_start = r_period_start;
    assign o_pending      = r_pending;
    assign o_active       = w_run;

endmodule

// File: tb/tb_pwm_update_sched.sv
// Directed self-checking bench for pwm_update_sched with PRESC_MAX=0
// (one PWM period = 256 clk). Expectations follow PWM_SYNC_UPDATE_EN.
module tb_pwm_update_sched;

`ifdef PWM_SYNC_UPDATE_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] out;
    logic        period_start;
    logic        pending;
    logic        active;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_update_sched_if #(.N_OUT(16)) cfg_if ();

    pwm_update_sched #(
        .N_OUT     (16),
        .PRESC_MAX (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_if         (cfg_if),
        .o_out          (out),
        .o_period_start (period_start),
        .o_pending      (pending),
        .o_active       (active)
    );

    // Present a configuration and strobe cfg_update for one clock.
    task automatic pulse(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        cfg_if.cfg_en_out = eo;
        cfg_if.cfg_en_pwm = ep;
        cfg_if.cfg_duty   = d;
        cfg_if.cfg_update = 1'b1;
        @(negedge clk);
        cfg_if.cfg_update = 1'b0;
    endtask

    // Advance to the next negedge where period_start is high (bounded).
    task automatic wait_ps(output bit found);
        found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            @(negedge clk);
            if (period_start) found = 1'b1;
        end
    endtask

    // Observe one full period of outputs after a period_start negedge.
    task automatic count_period(output int highs, output int bad, output int pend);
        highs = 0; bad = 0; pend = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            if (out[7:0] === 8'hFF) highs++;
            else if (out[7:0] !== 8'h00) bad++;
            if (out[15:8] !== 8'h00) bad++;
            if (pending !== 1'b0) pend++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_if.cfg_en_out = '0;
        cfg_if.cfg_en_pwm = '0;
        cfg_if.cfg_duty   = '0;
        cfg_if.cfg_update = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (out !== 16'h0000) begin miscompares++; $display("FAIL reset_out: got %h want 0000", out); end
        vectors++; if (period_start !== 1'b0) begin miscompares++; $display("FAIL reset_period_start: got %b want 0", period_start); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b want 0", pending); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b want 0", active); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL idle_active: got %b want 0", active); end
        $display("reset: out=%h active=%b pending=%b", out, active, pending);
    endtask

    task automatic test_constant();
        int pulses;
        int bad;
        pulse(16'h0001, 16'h0000, 8'd0);
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL const_active_early: got %b want 0", active); end
        @(negedge clk);
        vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL const_active: got %b want 1", active); end
        vectors++; if (period_start !== 1'b1) begin miscompares++; $display("FAIL const_first_ps: got %b want 1", period_start); end
        pulses = 0; bad = 0;
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            if (period_start) pulses++;
            if (out !== 16'h0001) bad++;
        end
        vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL const_ps_count: got %0d want 2", pulses); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL const_out: got %0d bad cycles want 0", bad); end
        $display("constant: period_start pulses=%0d out_bad=%0d", pulses, bad);
    endtask

    task automatic test_duty(input logic [7:0] d, input int exp_high);
        bit found;
        int h, b, p;
        pulse(16'h00FF, 16'h00FF, d);
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL duty%0d_ps: got %b want 1", d, found); end
        count_period(h, b, p);
        vectors++; if (h !== exp_high) begin miscompares++; $display("FAIL duty%0d_high: got %0d want %0d", d, h, exp_high); end
        vectors++; if (b !== 0) begin miscompares++; $display("FAIL duty%0d_shape: got %0d want 0", d, b); end
        vectors++; if (p !== 0) begin miscompares++; $display("FAIL duty%0d_pending: got %0d want 0", d, p); end
        $display("duty %0d: high=%0d bad=%0d", d, h, b);
    endtask

    task automatic test_pending();
        bit found;
        int h, b, p;
        pulse(16'h00FF, 16'h00FF, 8'd64);
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL pend_sync: got %b want 1", found); end
        repeat (100) @(negedge clk);
        pulse(16'h00FF, 16'h00FF, 8'd192);
        vectors++; if (pending !== SYNC) begin miscompares++; $display("FAIL pend_set: got %b want %b", pending, SYNC); end
`ifdef PWM_SYNC_UPDATE_EN
        found = 1'b0; b = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (period_start) found = 1'b1;
            else begin
                if (out[7:0] !== 8'h00) b++;
                if (pending !== 1'b1) b++;
            end
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL pend_boundary: got %b want 1", found); end
        vectors++; if (b !== 0) begin miscompares++; $display("FAIL pend_hold: got %0d want 0", b); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL pend_clear: got %b want 0", pending); end
`else
        @(negedge clk);
        vectors++; if (out[7:0] !== 8'hFF) begin miscompares++; $display("FAIL imm_out: got %h want ff", out[7:0]); end
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL imm_ps: got %b want 1", found); end
`endif
        count_period(h, b, p);
        vectors++; if (h !== 192) begin miscompares++; $display("FAIL pend_high: got %0d want 192", h); end
        vectors++; if (b !== 0 || p !== 0) begin miscompares++; $display("FAIL pend_period: got bad=%0d pend=%0d want 0/0", b, p); end
        $display("pending update 64->192: high=%0d", h);
    endtask

    task automatic test_same_cycle();
        bit found;
        int h, b, p;
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL same_sync: got %b want 1", found); end
        repeat (255) @(negedge clk);
        cfg_if.cfg_en_out = 16'h00FF;
        cfg_if.cfg_en_pwm = 16'h00FF;
        cfg_if.cfg_duty   = 8'd32;
        cfg_if.cfg_update = 1'b1;
        @(negedge clk);
        cfg_if.cfg_update = 1'b0;
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL same_pending: got %b want 0", pending); end
        vectors++; if (period_start !== 1'b1) begin miscompares++; $display("FAIL same_ps: got %b want 1", period_start); end
        count_period(h, b, p);
        vectors++; if (h !== 32) begin miscompares++; $display("FAIL same_high: got %0d want 32", h); end
        vectors++; if (b !== 0 || p !== 0) begin miscompares++; $display("FAIL same_period: got bad=%0d pend=%0d want 0/0", b, p); end
        $display("update on boundary: high=%0d pend_cycles=%0d", h, p);
    endtask

    task automatic test_back_to_back();
        bit found;
        int h, b, p;
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL b2b_sync: got %b want 1", found); end
        repeat (10) @(negedge clk);
        pulse(16'h00FF, 16'h00FF, 8'd100);
        repeat (9) @(negedge clk);
        pulse(16'h00FF, 16'h00FF, 8'd50);
        vectors++; if (pending !== SYNC) begin miscompares++; $display("FAIL b2b_pending: got %b want %b", pending, SYNC); end
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL b2b_ps: got %b want 1", found); end
        count_period(h, b, p);
        vectors++; if (h !== 50) begin miscompares++; $display("FAIL b2b_high: got %0d want 50", h); end
        vectors++; if (b !== 0 || p !== 0) begin miscompares++; $display("FAIL b2b_period: got bad=%0d pend=%0d want 0/0", b, p); end
        $display("back-to-back 100 then 50: high=%0d", h);
    endtask

    task automatic test_disable();
        bit found;
        int pulses;
        int bad;
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL dis_sync: got %b want 1", found); end
        repeat (10) @(negedge clk);
        pulse(16'h0000, 16'h0000, 8'd0);
        vectors++; if (active !== SYNC) begin miscompares++; $display("FAIL dis_active_early: got %b want %b", active, SYNC); end
        vectors++; if (pending !== SYNC) begin miscompares++; $display("FAIL dis_pending: got %b want %b", pending, SYNC); end
`ifdef PWM_SYNC_UPDATE_EN
        vectors++; if (out[7:0] !== 8'hFF) begin miscompares++; $display("FAIL dis_live: got %h want ff", out[7:0]); end
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL dis_boundary: got %b want 1", found); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL dis_active_bnd: got %b want 0", active); end
`endif
        repeat (2) @(negedge clk);
        vectors++; if (out !== 16'h0000) begin miscompares++; $display("FAIL dis_out: got %h want 0000", out); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL dis_active: got %b want 0", active); end
        pulses = 0; bad = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (period_start) pulses++;
            if (out !== 16'h0000) bad++;
        end
        vectors++; if (pulses !== 0 || bad !== 0) begin miscompares++; $display("FAIL dis_idle: got ps=%0d outbad=%0d want 0/0", pulses, bad); end
        $display("disable: active=%b out=%h", active, out);
    endtask

    task automatic test_reset_mid();
        bit found;
        pulse(16'hFFFF, 16'h0000, 8'd0);
        wait_ps(found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL rst_start: got %b want 1", found); end
        repeat (140) @(negedge clk);
        pulse(16'hFFFF, 16'h0000, 8'd0);
        repeat (9) @(negedge clk);
        vectors++; if (out !== 16'hFFFF) begin miscompares++; $display("FAIL rst_pre_out: got %h want ffff", out); end
        vectors++; if (pending !== SYNC) begin miscompares++; $display("FAIL rst_pre_pending: got %b want %b", pending, SYNC); end
        rst_n = 1'b0;
        #1;
        vectors++; if (out !== 16'h0000) begin miscompares++; $display("FAIL rst_out: got %h want 0000", out); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL rst_pending: got %b want 0", pending); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL rst_active: got %b want 0", active); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if (out !== 16'h0000 || active !== 1'b0) begin miscompares++; $display("FAIL rst_idle: got out=%h active=%b want 0000/0", out, active); end
        pulse(16'h0002, 16'h0000, 8'd0);
        @(negedge clk);
        vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL rst_restart: got %b want 1", active); end
        @(negedge clk);
        vectors++; if (out !== 16'h0002) begin miscompares++; $display("FAIL rst_restart_out: got %h want 0002", out); end
        pulse(16'h0004, 16'h0000, 8'd0);
        @(negedge clk);
        vectors++; if (out !== (SYNC ? 16'h0002 : 16'h0004)) begin
            miscompares++; $display("FAIL run_update_out: got %h want %h", out, (SYNC ? 16'h0002 : 16'h0004));
        end
        $display("reset mid-period then restart: out=%h active=%b", out, active);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_duty(8'd64, 64);
        test_duty(8'd0, 0);
        test_duty(8'd255, 256);
        test_pending();
        test_same_cycle();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_update_sched.md
Name: pwm_update_sched

Overview:
- Schedules how SPI-written configuration reaches the PWM output stage.
- Inputs: the SPI register values (output enables, PWM enables, duty) and a one-cycle commit strobe from the SPI slave.
- Holds these values in shadow registers and applies them atomically at a PWM period boundary, so outputs never glitch mid-period.
- Owns the PWM timebase: prescaler plus 8-bit phase counter. Drives 16 output pins.

Parameters:
- N_OUT, 16: number of output channels.
- PRESC_MAX, 12: prescaler terminal count. PWM period = (PRESC_MAX+1)*256 clk cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_en_out  in  N_OUT  per-channel output enable (SPI regs 0/1)
- cfg_en_pwm  in  N_OUT  per-channel PWM-mode select (SPI regs 2/3)
- cfg_duty  in  8  shared duty cycle (SPI reg 4)
- cfg_update  in  1  one-cycle pulse: SPI slave has committed a register write
- out  out  N_OUT  registered channel outputs
- period_start  out  1  one-cycle pulse on the first phase-0 tick of each period
- pending  out  1  an accepted update is waiting for the boundary
- active  out  1  state == RUN

Behaviour:
- Reset: out=0, period_start=0, pending=0, active=0. Shadow en_out/en_pwm/duty=0. Prescaler=0, phase=0. State=IDLE.
- Timebase:
  - Prescaler counts 0..PRESC_MAX and wraps; tick fires when prescaler==PRESC_MAX.
  - phase increments on tick, wrapping 255->0.
  - boundary = tick while phase==255.
  - Timebase runs only in RUN; in IDLE, prescaler and phase are held at 0.
- Channel function, with shadow values:
  - pwm_raw = (duty==8'hFF) ? 1 : (phase < duty). duty=0 gives constant 0; duty=255 gives constant 1.
  - out[i] <= en_out[i] & (en_pwm[i] ? pwm_raw : 1).
  - Output is registered: one clk of latency from phase/shadow to pin.
- States:
  - IDLE:
    - cfg_update loads the shadow registers from cfg_* on the next edge; pending stays 0.
    - If the loaded en_out != 0, go to RUN with phase=0 and prescaler=0.
    - period_start pulses on the first cycle of RUN.
  - RUN:
    - cfg_update sets pending=1 (the cfg_* values are not captured yet).
    - On boundary with pending=1: load shadow from the cfg_* values present on that cycle, clear pending.
    - On boundary, period_start pulses on the next cycle, when phase==0.
    - If the newly loaded en_out==0: go to IDLE, zero the timebase, out=0 from the next cycle.
- Simultaneous cfg_update and boundary: loaded in that boundary; pending ends 0.
- Multiple cfg_update pulses within one period: last-write-wins, because cfg_* is sampled at the boundary. Single load, single pending clear.
- cfg_update while pending=1: no effect beyond keeping pending=1.
- Reset mid-period: all state returns to reset values immediately (asynchronous). Outputs are low until a new update arrives.

Optional Feature:
- Macro: PWM_SYNC_UPDATE_EN.
- Defined: the boundary-synchronised update described above.
- Undefined:
  - In both states, cfg_update loads the shadow registers on the next edge.
  - pending is tied 0.
  - The phase counter is not reset on the update; the IDLE->RUN and RUN->IDLE transitions still apply.

Decomposition:
- Package pwm_pkg: PHASE_W=8, DUTY_FULL=8'hFF, default N_OUT, state enum {IDLE, RUN}.
- One sub-module, pwm_timebase:
  - Contains the prescaler and phase counter.
  - Inputs: run enable, synchronous clear.
  - Outputs: phase[7:0], tick, boundary.
- The scheduler FSM, shadow registers and output stage live in pwm_update_sched.

Test Plan (PRESC_MAX=0, so period = 256 clk):
- Reset, then cfg_update with en_out=16'h0001, en_pwm=0 -> active=1 two cycles later; out[0]=1 constant; out[15:1]=0; period_start pulses every 256 clk.
- en_out=en_pwm=16'h00FF, duty=64 -> out[7:0] high for exactly 64 of every 256 clk; duty=0 gives constant 0; duty=255 gives constant 1.
- In RUN at phase 100, cfg_update with duty 64->192 -> pending=1; duty stays 64 until boundary; first 192-high period starts with period_start; pending clears at boundary.
- cfg_update asserted on the same cycle as boundary -> new values active in the following period; pending never asserts.
- In RUN, update to en_out=0 -> out stays live until boundary, then all 0; active=0; phase held at 0.
- rst_n pulsed low at phase 150 -> out=0, pending=0, active=0 immediately; with PWM_SYNC_UPDATE_EN undefined, a RUN update changes out within 2 clk.
